// File: rtl/csr_row_sequencer.sv
// csr_row_sequencer: walks one CSR row of packed (value, column) word pairs,
// issuing one even read address per non-zero under valid/ready, and reports
// row completion, a running beat total and sticky descriptor error flags.
module csr_row_sequencer #(
    parameter int ADDR_W = 10,
    parameter int TOT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              row_valid,
    output logic              row_ready,
    input  logic [ADDR_W:0]   row_start,
    input  logic [ADDR_W:0]   row_end,
    input  logic              abort,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   rd_addr,
    output logic              rd_last,
    output logic              row_done,
    output logic              busy,
    output logic [TOT_W-1:0]  nnz_total,
    output logic              err_range,
    output logic              err_align
);

    typedef enum logic {IDLE, RUN} state_t;

    // Comparisons run one bit wider than the bus so addr+2 at the top of
    // the address space does not wrap back to zero.
    localparam logic [ADDR_W+1:0] STEP_W = (ADDR_W+2)'(2);
    localparam logic [ADDR_W:0]   STEP   = (ADDR_W+1)'(2);

    state_t          state, state_nxt;
    logic [ADDR_W:0] end_q;
    logic [ADDR_W:0] aligned;
    logic            accept;
    logic            beat;
    logic            non_empty;
    logic            last_beat;

    assign aligned   = {row_start[ADDR_W:1], 1'b0};
    assign accept    = row_valid && row_ready;
    assign beat      = rd_valid && rd_ready;
    assign non_empty = {1'b0, row_end} > {1'b0, aligned};
    assign last_beat = beat && rd_last && !abort;

    assign row_ready = (state == IDLE) && !reset;
    assign busy      = (state == RUN);
    assign rd_valid  = (state == RUN);
    // An odd row_end rounds up: the pair straddling it is still issued.
    assign rd_last   = rd_valid && (({1'b0, rd_addr} + STEP_W) >= {1'b0, end_q});

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: abort wins over the last-beat exit; empty rows never enter RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && non_empty) state_nxt = RUN;
            RUN:  if (abort || (beat && rd_last)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address walk, row end capture, done pulse, beat total and error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr   <= '0;
            end_q     <= '0;
            row_done  <= 1'b0;
            nnz_total <= '0;
            err_range <= 1'b0;
            err_align <= 1'b0;
        end else begin
            row_done <= 1'b0;
            if (accept) begin
                rd_addr <= aligned;
                end_q   <= row_end;
                if (row_start[0])        err_align <= 1'b1;
                if (row_end < row_start) err_range <= 1'b1;
                // Empty and range-error rows complete without issuing beats.
                if (!non_empty)          row_done  <= 1'b1;
            end
            if (beat) begin
                // A beat handshaking alongside abort is still counted.
                nnz_total <= nnz_total + TOT_W'(1);
                if (!rd_last && !abort) rd_addr <= rd_addr + STEP;
            end
            if (last_beat) row_done <= 1'b1;
        end
    end

endmodule
